// File: rtl/ec_pkg.sv
// Shared constants for the AV1 multi-symbol arithmetic encoder pipeline.
package ec_pkg;

  localparam int RANGE_WIDTH    = 16;
  localparam int SYMBOL_WIDTH   = 4;
  localparam int LUT_DATA_WIDTH = 16;
  localparam int D_WIDTH        = 5;

  // Range value after reset or init: a normalised range of one half.
  localparam logic [RANGE_WIDTH-1:0] RANGE_INIT = 16'h8000;

  // Minimum per-symbol probability term; stage 1 folds it into lut_v.
  localparam int EC_MIN_PROB = 4;

  // Unsigned 17-bit subtraction of two range-domain operands.
  function automatic logic [RANGE_WIDTH:0] sub17(input logic [RANGE_WIDTH:0] a,
                                                 input logic [RANGE_WIDTH:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/lzc_16.sv
// Combinational 16-bit leading-zero counter. All-zero input yields 16.
module lzc_16
  import ec_pkg::*;
(
  input  logic [15:0] data_i,
  output logic [4:0]  count_o
);

  logic [4:0] count_s;

  // Scan from LSB upward so the highest set bit determines the count.
  always_comb begin
    count_s = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (data_i[i]) begin
        count_s = 5'(15 - i);
      end else begin
        count_s = count_s;
      end
    end
  end

  assign count_o = count_s;

endmodule

// File: rtl/stage_2.sv
// Encoder stage 2: owns the range register, computes u/v, the new range,
// the low increment and the renormalisation shift for stage 3.
module stage_2
  import ec_pkg::*;
(
  input  logic                      clk_stage_2,
  input  logic                      reset,
  input  logic                      init,
  input  logic                      in_valid,
  input  logic [RANGE_WIDTH-1:0]    UU,
  input  logic [RANGE_WIDTH-1:0]    VV,
  input  logic                      COMP_mux_1,
  input  logic                      bool_out,
  input  logic [SYMBOL_WIDTH-1:0]   out_symbol,
  input  logic [LUT_DATA_WIDTH-1:0] lut_u_out,
  input  logic [LUT_DATA_WIDTH-1:0] lut_v_out,
  output logic                      out_valid,
  output logic [RANGE_WIDTH-1:0]    low_add,
  output logic [D_WIDTH-1:0]        shift_d,
  output logic [RANGE_WIDTH-1:0]    range_out,
  output logic                      err
);

  // Align register: holds stage-1 fields until the LUT data arrives.
  logic                   a_valid_q;
  logic [RANGE_WIDTH-1:0] a_uu_q;
  logic [RANGE_WIDTH-1:0] a_vv_q;
  logic                   a_comp_q;
  logic                   a_multi_q;
  logic                   a_bit_q;

  // Architectural state and registered outputs.
  logic [RANGE_WIDTH-1:0] range_q,     range_d;
  logic                   out_valid_q, out_valid_d;
  logic [RANGE_WIDTH-1:0] low_add_q,   low_add_d;
  logic [D_WIDTH-1:0]     shift_q,     shift_d_d;
  logic                   err_q,       err_d;

  // Compute-cycle datapath.
  logic [7:0]             rs_s;
  logic [23:0]            prod_u_s;
  logic [23:0]            prod_v_s;
  logic [RANGE_WIDTH:0]   u_s;
  logic [RANGE_WIDTH:0]   v_s;
  logic [RANGE_WIDTH:0]   r_s;
  logic [RANGE_WIDTH:0]   low_raw_s;
  logic [RANGE_WIDTH:0]   rng_raw_s;
  logic                   under_s;
  logic [4:0]             lzc_s;
  logic                   bad_s;
  logic [RANGE_WIDTH-1:0] norm_s;
  logic                   unused_s;

  // Capture stage-1 fields on in_valid; a_valid follows in_valid every cycle.
  always_ff @(posedge clk_stage_2 or negedge reset) begin
    if (!reset) begin
      a_valid_q <= 1'b0;
      a_uu_q    <= 16'd0;
      a_vv_q    <= 16'd0;
      a_comp_q  <= 1'b0;
      a_multi_q <= 1'b0;
      a_bit_q   <= 1'b0;
    end else begin
      a_valid_q <= in_valid;
      if (in_valid) begin
        a_uu_q    <= UU;
        a_vv_q    <= VV;
        a_comp_q  <= COMP_mux_1;
        a_multi_q <= bool_out;
        a_bit_q   <= out_symbol[0];
      end else begin
        a_uu_q    <= a_uu_q;
        a_vv_q    <= a_vv_q;
        a_comp_q  <= a_comp_q;
        a_multi_q <= a_multi_q;
        a_bit_q   <= a_bit_q;
      end
    end
  end

  // Scaled bounds: only the top byte of range enters the multiply.
  assign rs_s     = range_q[15:8];
  assign prod_u_s = 24'(rs_s) * 24'(a_uu_q);
  assign prod_v_s = 24'(rs_s) * 24'(a_vv_q);
  assign u_s      = prod_u_s[17:1] + {1'b0, lut_u_out};
  assign v_s      = prod_v_s[17:1] + {1'b0, lut_v_out};
  assign r_s      = {1'b0, range_q};

  // Select low increment and raw range for the active coding path.
  always_comb begin
    low_raw_s = 17'd0;
    rng_raw_s = 17'd0;
    under_s   = 1'b0;
    if (a_multi_q) begin
      if (a_comp_q) begin
        under_s   = (u_s > r_s) || (v_s > u_s);
        low_raw_s = sub17(r_s, u_s);
        rng_raw_s = sub17(u_s, v_s);
      end else begin
        under_s   = (v_s > r_s);
        low_raw_s = 17'd0;
        rng_raw_s = sub17(r_s, v_s);
      end
    end else begin
      under_s = (v_s > r_s);
      if (a_bit_q) begin
        low_raw_s = sub17(r_s, v_s);
        rng_raw_s = v_s;
      end else begin
        low_raw_s = 17'd0;
        rng_raw_s = sub17(r_s, v_s);
      end
    end
  end

  lzc_16 u_lzc (
    .data_i  (rng_raw_s[15:0]),
    .count_o (lzc_s)
  );

  // A zero range shows up as a count of 16 from the LZC.
  assign bad_s  = under_s || (lzc_s == 5'd16);
  assign norm_s = rng_raw_s[15:0] << lzc_s[3:0];

  // Next-state for range, error and the output register.
  always_comb begin
    range_d     = range_q;
    out_valid_d = 1'b0;
    low_add_d   = low_add_q;
    shift_d_d   = shift_q;
    err_d       = err_q;
    if (init) begin
      range_d     = RANGE_INIT;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (a_valid_q) begin
      out_valid_d = 1'b1;
      if (bad_s) begin
        err_d     = 1'b1;
        low_add_d = 16'd0;
        shift_d_d = 5'd0;
      end else begin
        range_d   = norm_s;
        low_add_d = low_raw_s[15:0];
        shift_d_d = lzc_s;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Range, error and output registers.
  always_ff @(posedge clk_stage_2 or negedge reset) begin
    if (!reset) begin
      range_q     <= RANGE_INIT;
      out_valid_q <= 1'b0;
      low_add_q   <= 16'd0;
      shift_q     <= 5'd0;
      err_q       <= 1'b0;
    end else begin
      range_q     <= range_d;
      out_valid_q <= out_valid_d;
      low_add_q   <= low_add_d;
      shift_q     <= shift_d_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign low_add   = low_add_q;
  assign shift_d   = shift_q;
  assign range_out = range_q;
  assign err       = err_q;

  // Bits that are structurally unused (upper symbol bits, product tails).
  assign unused_s = ^{out_symbol[3:1], prod_u_s[23:18], prod_u_s[0],
                      prod_v_s[23:18], prod_v_s[0], low_raw_s[16], rng_raw_s[16]};

endmodule

// File: tb/tb_stage_2.sv
// Directed self-checking bench for stage_2.
module tb_stage_2;

  logic        clk_stage_2 = 1'b0;
  logic        reset;
  logic        init;
  logic        in_valid;
  logic [15:0] UU;
  logic [15:0] VV;
  logic        COMP_mux_1;
  logic        bool_out;
  logic [3:0]  out_symbol;
  logic [15:0] lut_u_out;
  logic [15:0] lut_v_out;
  logic        out_valid;
  logic [15:0] low_add;
  logic [4:0]  shift_d;
  logic [15:0] range_out;
  logic        err;

  int errors = 0;
  int checks = 0;

  stage_2 dut (
    .clk_stage_2 (clk_stage_2),
    .reset       (reset),
    .init        (init),
    .in_valid    (in_valid),
    .UU          (UU),
    .VV          (VV),
    .COMP_mux_1  (COMP_mux_1),
    .bool_out    (bool_out),
    .out_symbol  (out_symbol),
    .lut_u_out   (lut_u_out),
    .lut_v_out   (lut_v_out),
    .out_valid   (out_valid),
    .low_add     (low_add),
    .shift_d     (shift_d),
    .range_out   (range_out),
    .err         (err)
  );

  always #5 clk_stage_2 = ~clk_stage_2;

  task automatic tick();
    @(posedge clk_stage_2);
    #1;
  endtask

  task automatic present(input logic multi, input logic comp, input logic bitv,
                         input logic [15:0] uu, input logic [15:0] vv);
    in_valid   = 1'b1;
    bool_out   = multi;
    COMP_mux_1 = comp;
    out_symbol = {3'b101, bitv};
    UU         = uu;
    VV         = vv;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    UU         = 16'd0;
    VV         = 16'd0;
    COMP_mux_1 = 1'b0;
    bool_out   = 1'b0;
    out_symbol = 4'd0;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; idle_in(); lut_u_out = 16'd0; lut_v_out = 16'd0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (range_out !== 16'h8000) begin errors++; $display("FAIL reset_range: got %h want 8000", range_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (low_add !== 16'd0 || shift_d !== 5'd0) begin errors++; $display("FAIL reset_outs: got low=%0d sh=%0d want 0/0", low_add, shift_d); end
  endtask

  task automatic test_bool_one();
    do_init();
    present(1'b0, 1'b0, 1'b1, 16'd0, 16'd256);
    tick();
    idle_in(); lut_u_out = 16'd0; lut_v_out = 16'd4;
    tick();
    lut_v_out = 16'd0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bool1_valid: got %b want 1", out_valid); end
    checks++; if (low_add !== 16'd16380) begin errors++; $display("FAIL bool1_low: got %0d want 16380", low_add); end
    checks++; if (shift_d !== 5'd1) begin errors++; $display("FAIL bool1_shift: got %0d want 1", shift_d); end
    checks++; if (range_out !== 16'h8008) begin errors++; $display("FAIL bool1_range: got %h want 8008", range_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", out_valid); end
    checks++; if (low_add !== 16'd16380 || shift_d !== 5'd1) begin errors++; $display("FAIL bubble_hold: got low=%0d sh=%0d want 16380/1", low_add, shift_d); end
  endtask

  task automatic test_bool_zero();
    do_init();
    present(1'b0, 1'b0, 1'b0, 16'd0, 16'd256);
    tick();
    idle_in(); lut_v_out = 16'd4;
    tick();
    lut_v_out = 16'd0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bool0_valid: got %b want 1", out_valid); end
    checks++; if (low_add !== 16'd0) begin errors++; $display("FAIL bool0_low: got %0d want 0", low_add); end
    checks++; if (shift_d !== 5'd2) begin errors++; $display("FAIL bool0_shift: got %0d want 2", shift_d); end
    checks++; if (range_out !== 16'hFFF0) begin errors++; $display("FAIL bool0_range: got %h want fff0", range_out); end
  endtask

  task automatic test_back_to_back();
    do_init();
    present(1'b1, 1'b1, 1'b0, 16'd256, 16'd128);
    tick();
    present(1'b1, 1'b0, 1'b0, 16'd0, 16'd384);
    lut_u_out = 16'd12; lut_v_out = 16'd8;
    tick();
    idle_in(); lut_u_out = 16'd0; lut_v_out = 16'd8;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL comp1_valid: got %b want 1", out_valid); end
    checks++; if (low_add !== 16'd16372) begin errors++; $display("FAIL comp1_low: got %0d want 16372", low_add); end
    checks++; if (shift_d !== 5'd2) begin errors++; $display("FAIL comp1_shift: got %0d want 2", shift_d); end
    checks++; if (range_out !== 16'h8010) begin errors++; $display("FAIL comp1_range: got %h want 8010", range_out); end
    tick();
    lut_v_out = 16'd0;
    // r = 0x8010: rng_raw = 32784 - 24584 = 0x2008 -> shift 2, range 0x8020
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL comp0_valid: got %b want 1", out_valid); end
    checks++; if (low_add !== 16'd0) begin errors++; $display("FAIL comp0_low: got %0d want 0", low_add); end
    checks++; if (shift_d !== 5'd2) begin errors++; $display("FAIL comp0_shift: got %0d want 2", shift_d); end
    checks++; if (range_out !== 16'h8020) begin errors++; $display("FAIL comp0_range: got %h want 8020", range_out); end
  endtask

  task automatic test_init_discard();
    present(1'b0, 1'b0, 1'b1, 16'd0, 16'd256);
    tick();
    idle_in(); lut_v_out = 16'd4; init = 1'b1;
    tick();
    init = 1'b0; lut_v_out = 16'd0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discard_valid: got %b want 0", out_valid); end
    checks++; if (range_out !== 16'h8000) begin errors++; $display("FAIL discard_range: got %h want 8000", range_out); end
  endtask

  task automatic test_underflow();
    do_init();
    present(1'b1, 1'b0, 1'b0, 16'd0, 16'd1023);
    tick();
    idle_in(); lut_v_out = 16'd8;
    tick();
    lut_v_out = 16'd0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL uf_err: got %b want 1", err); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uf_valid: got %b want 1", out_valid); end
    checks++; if (range_out !== 16'h8000) begin errors++; $display("FAIL uf_range: got %h want 8000", range_out); end
    checks++; if (low_add !== 16'd0 || shift_d !== 5'd0) begin errors++; $display("FAIL uf_outs: got low=%0d sh=%0d want 0/0", low_add, shift_d); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", err); end
    init = 1'b1;
    present(1'b0, 1'b0, 1'b1, 16'd0, 16'd256);
    tick();
    init = 1'b0; idle_in(); lut_v_out = 16'd4;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b want 0", err); end
    checks++; if (range_out !== 16'h8000 || out_valid !== 1'b0) begin errors++; $display("FAIL init_state: got range=%h v=%b want 8000/0", range_out, out_valid); end
    tick();
    lut_v_out = 16'd0;
    checks++; if (out_valid !== 1'b1 || range_out !== 16'h8008) begin errors++; $display("FAIL init_sym: got v=%b range=%h want 1/8008", out_valid, range_out); end
    checks++; if (low_add !== 16'd16380 || err !== 1'b0) begin errors++; $display("FAIL init_low: got low=%0d err=%b want 16380/0", low_add, err); end
  endtask

  initial begin
    test_reset();
    test_bool_one();
    test_bool_zero();
    test_back_to_back();
    test_init_discard();
    test_underflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stage_2.md
# stage_2

Second pipeline stage of the AV1 multi-symbol arithmetic encoder. Consumes stage-1 outputs (scaled CDF bounds UU/VV, the COMP_mux_1 compare flag, the inverted bool flag, the symbol, and the synchronous LUT corrections lut_u/lut_v), and owns the encoder range state. Each cycle it computes u/v, the new range, the low-increment, and the renormalisation shift, then hands these to stage 3, which holds low and emits carries. Sustains one symbol per clock with no backpressure.

## Interface
- RANGE_WIDTH, 16, width of range, FL/FH-derived operands, and low_add
- SYMBOL_WIDTH, 4, symbol width
- LUT_DATA_WIDTH, 16, width of lut_u_out/lut_v_out
- D_WIDTH, 5, width of the renormalisation shift output
- Clock: single clock `clk_stage_2`, rising edge.
- Reset: `reset`, asynchronous, active-low.
- clk_stage_2  in  1  clock; the same clock drives stage_1's LUTs
- reset  in  1  asynchronous active-low reset
- init  in  1  synchronous pulse; restart range for a new tile/frame
- in_valid  in  1  stage-1 inputs are valid this cycle; LUT address is presented this cycle
- UU, VV  in  RANGE_WIDTH  FL>>6 and FH>>6 from stage 1
- COMP_mux_1  in  1  1 when FL < 32768
- bool_out  in  1  from stage 1: 1 = multi-symbol, 0 = boolean
- out_symbol  in  SYMBOL_WIDTH  symbol; bit 0 is the bool value
- lut_u_out, lut_v_out  in  LUT_DATA_WIDTH  LUT data, valid one cycle after in_valid
- out_valid  out  1  outputs below are valid
- low_add  out  RANGE_WIDTH  value stage 3 adds to low
- shift_d  out  D_WIDTH  left-shift count for low; range 0..15
- range_out  out  RANGE_WIDTH  current normalised range register
- err  out  1  sticky error flag

## Operation
- Align register (A): on in_valid, capture UU, VV, COMP_mux_1, bool_out, and out_symbol[0], and set a_valid. LUT q arrives in the same cycle that A is valid.
- Compute (cycle after capture, a_valid=1), r = range register:
  - rs = r[15:8]
  - pu = (rs*UU)>>1 and pv = (rs*VV)>>1, 17-bit unsigned
  - u = pu + lut_u_out and v = pv + lut_v_out, 17-bit
- Multi-symbol, COMP=1: low_add = r − u; rng_raw = u − v.
- Multi-symbol, COMP=0: low_add = 0; rng_raw = r − v.
- Boolean (bool_out=0), using v only; lut_v_out supplies the EC_MIN_PROB term of 4:
  - bit=1: low_add = r − v; rng_raw = v.
  - bit=0: low_add = 0; rng_raw = r − v.
- Renormalise:
  - shift_d = leading-zero count of rng_raw[15:0].
  - range ← rng_raw << shift_d, so range bit 15 is always 1 after an update.
- Error cases:
  - Underflow (v > r, u > r, or v > u on the path used) or rng_raw = 0: set err, leave range unchanged, shift_d = 0, low_add = 0. out_valid still asserts.
  - err clears only on reset or init.
- init:
  - range ← 0x8000 and err ← 0.
  - A symbol in compute during init is discarded: no out_valid, no range update.
  - in_valid in the init cycle is captured and computed against 0x8000.
- Reset mid-stream: all in-flight symbols are lost. There is no recovery; upstream must re-init.

## Timing
- Reset values: range = 0x8000; a_valid, out_valid, low_add, shift_d, and err = 0. range_out = 0x8000.
- Latency: in_valid at cycle n produces out_valid at n+2. Outputs are registered at the end of the compute cycle n+1.
- The range feedback loop (multiply, subtract, LZC, shift) closes in one cycle. Back-to-back in_valid every cycle is required to work, with each symbol using the range written by its predecessor.
- range_out updates in the same cycle as the matching out_valid.
- in_valid=0 produces a bubble: out_valid=0, and low_add/shift_d hold their last values.

## Structure
- Shared package `ec_pkg`:
  - RANGE_INIT = 16'h8000
  - EC_MIN_PROB = 4
  - Width constants RANGE_WIDTH, SYMBOL_WIDTH, and D_WIDTH, shared with stage_1 and stage_3.
- Sub-module `lzc_16`: combinational 16-bit leading-zero counter, output 0..16. An output of 16 flags the zero error.
- Everything else (align register, arithmetic, range register, output register) lives in stage_2.

## Test plan
- Reset, then idle → range_out = 0x8000, out_valid = 0, err = 0.
- Bool, bit=1, VV = 256, lut_v = 4, range 0x8000 → v = 16388, low_add = 16380, shift_d = 1, range_out = 0x8008.
- Bool, bit=0, same inputs → low_add = 0, rng_raw = 0x3FFC, shift_d = 2, range_out = 0xFFF0.
- Multi-symbol, COMP=1, UU = 256, lut_u = 12, VV = 128, lut_v = 8, range 0x8000 → u = 16396, v = 8200, low_add = 16372, shift_d = 2, range_out = 0x8010.
- Multi-symbol, COMP=0, VV = 384, lut_v = 8, range 0x8000 → low_add = 0, rng_raw = 0x1FF8, shift_d = 3, range_out = 0xFFC0. Feed this back-to-back after the previous case and check that the second symbol uses 0x8010.
- Underflow: range 0x8000, COMP=0, VV = 1023, lut_v = 8 → err = 1, range unchanged. Then init together with in_valid → err = 0, and the captured symbol computes against 0x8000.
